// File: rtl/start_key_pkg.sv
// Shared types and constants for the start-key conditioner.
// The seed helper keeps captured values inside the Lehmer generator's legal range.
package start_key_pkg;

    typedef enum logic [1:0] {
        StUp,
        StFall,
        StDown,
        StRise
    } key_state_e;

    localparam logic [31:0] SEED_DEFAULT = 32'd1;
    localparam logic [30:0] LEHMER_MOD   = 31'h7FFFFFFF;

    // 0 and the modulus are fixed points of the generator, so both map to the default seed.
    function automatic logic [31:0] legalise_seed(input logic [31:0] raw);
        if (raw[30:0] == 31'd0 || raw[30:0] == LEHMER_MOD) begin
            return SEED_DEFAULT;
        end
        return {1'b0, raw[30:0]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a caller-supplied reset value.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= i_rst_val;
            sync_q <= i_rst_val;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/start_key_ctrl.sv
// Debounces the active-low start key, pulses o_start once per accepted press and
// captures a legal Lehmer seed from a free-running counter at that instant.
module start_key_ctrl
    import start_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_key_n,
    output logic        o_start,
    output logic [31:0] o_seed,
    output logic        o_pressed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      r_free_q;
    logic             start_d;
    logic [31:0]      seed_d;
    logic             pressed_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_key (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rst_val (1'b1),
        .i_d       (i_key_n),
        .o_q       (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        seed_d  = o_seed;
        unique case (state_q)
            StUp: begin
                if (!s) begin
                    state_d = StFall;
                    cnt_d   = CNT_ONE;
                end
            end
            StFall: begin
                if (s) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StDown;
                    cnt_d   = '0;
                    start_d = 1'b1;
                    seed_d  = legalise_seed(r_free_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StDown: begin
                if (s) begin
                    state_d = StRise;
                    cnt_d   = CNT_ONE;
                end
            end
            StRise: begin
                if (!s) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = StUp;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == StDown) || (state_d == StRise);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StUp;
            cnt_q     <= '0;
            r_free_q  <= 32'd0;
            o_start   <= 1'b0;
            o_seed    <= SEED_DEFAULT;
            o_pressed <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_free_q  <= r_free_q + 32'd1;
            o_start   <= start_d;
            o_seed    <= seed_d;
            o_pressed <= pressed_d;
        end
    end

endmodule

// File: tb/tb_start_key_ctrl.sv
// Self-checking bench for start_key_ctrl with DEBOUNCE_CYCLES=4, directed scenarios
// plus randomized key activity checked against a streak-based reference model.
module tb_start_key_ctrl;

    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_key_n = 1'b1;
    logic        o_start;
    logic [31:0] o_seed;
    logic        o_pressed;

    int tests_run = 0;
    int fails = 0;

    // Reference model: key history, streak of equal synchronized samples, debounced level.
    logic        m_h1, m_h2, m_sv;
    int          m_streak;
    logic        m_pressed, m_start;
    logic [31:0] m_seed, m_rfree;

    start_key_ctrl #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_key_n   (i_key_n),
        .o_start   (o_start),
        .o_seed    (o_seed),
        .o_pressed (o_pressed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_legal(input logic [31:0] v);
        longint unsigned low;
        low = longint'(v) % 64'd2147483648;
        if (low == 0 || low == 64'd2147483647) return 32'd1;
        return 32'(low);
    endfunction

    task automatic model_edge(input logic k, input logic r);
        logic s;
        if (r) begin
            m_h1 = 1'b1; m_h2 = 1'b1; m_sv = 1'b1; m_streak = 0;
            m_pressed = 1'b0; m_start = 1'b0; m_seed = 32'd1; m_rfree = 32'd0;
        end else begin
            s = m_h2;
            m_h2 = m_h1;
            m_h1 = k;
            if (s == m_sv) m_streak++;
            else begin
                m_sv = s;
                m_streak = 1;
            end
            m_start = 1'b0;
            // A full streak of samples disagreeing with the level flips it.
            if (m_streak >= DEB && m_pressed == s) begin
                m_pressed = !s;
                if (m_pressed) begin
                    m_start = 1'b1;
                    m_seed  = m_legal(m_rfree);
                end
            end
            m_rfree = m_rfree + 32'd1;
        end
    endtask

    task automatic cycle(input logic k, input logic r);
        @(negedge clk);
        i_key_n = k;
        i_rst   = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1);
            tests_run++;
            if (o_start !== 1'b0) begin
                fails++; $display("FAIL reset_start got=%b exp=0", o_start);
            end
            tests_run++;
            if (o_pressed !== 1'b0) begin
                fails++; $display("FAIL reset_pressed got=%b exp=0", o_pressed);
            end
            tests_run++;
            if (o_seed !== 32'd1) begin
                fails++; $display("FAIL reset_seed got=%h exp=00000001", o_seed);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        for (int e = 0; e < 10; e++) begin
            cycle(1'b0, 1'b0);
            tests_run++;
            if (o_start !== (e == 5)) begin
                fails++; $display("FAIL clean_start e=%0d got=%b exp=%b", e, o_start, e == 5);
            end
            tests_run++;
            if (o_pressed !== (e >= 5)) begin
                fails++; $display("FAIL clean_pressed e=%0d got=%b exp=%b", e, o_pressed, e >= 5);
            end
            tests_run++;
            if (o_seed !== ((e >= 5) ? 32'd5 : 32'd1)) begin
                fails++; $display("FAIL clean_seed e=%0d got=%h", e, o_seed);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 0; e < 18; e++) begin
            cycle((e < 2) ? 1'b0 : 1'b1, 1'b0);
            tests_run++;
            if (o_start !== 1'b0 || o_pressed !== 1'b0 || o_seed !== 32'd1) begin
                fails++;
                $display("FAIL glitch e=%0d got start=%b pressed=%b seed=%h exp 0,0,00000001",
                         e, o_start, o_pressed, o_seed);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic k;
        do_reset();
        for (int e = 0; e < 22; e++) begin
            k = (e < 8) ? 1'b0 : (e == 9) ? 1'b0 : 1'b1;
            cycle(k, 1'b0);
            if (e >= 6) begin
                tests_run++;
                if (o_pressed !== (e < 15)) begin
                    fails++; $display("FAIL bounce_pressed e=%0d got=%b exp=%b", e, o_pressed, e < 15);
                end
                tests_run++;
                if (o_start !== 1'b0) begin
                    fails++; $display("FAIL bounce_start e=%0d got=%b exp=0", e, o_start);
                end
            end
        end
    endtask

    task automatic test_seed_legal();
        logic [31:0] forced [3];
        logic [31:0] expect_seed [3];
        int pulses;
        logic [31:0] got;
        forced[0] = 32'h80000000; expect_seed[0] = 32'd1;
        forced[1] = 32'h7FFFFFFF; expect_seed[1] = 32'd1;
        forced[2] = 32'h80000005; expect_seed[2] = 32'd5;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            force dut.r_free_q = forced[t];
            pulses = 0;
            got = 32'hDEADBEEF;
            for (int e = 0; e < 9; e++) begin
                cycle(1'b0, 1'b0);
                if (o_start === 1'b1) begin
                    pulses++;
                    got = o_seed;
                end
            end
            release dut.r_free_q;
            tests_run++;
            if (pulses != 1 || got !== expect_seed[t]) begin
                fails++;
                $display("FAIL seed_legal raw=%h got pulses=%0d seed=%h exp pulses=1 seed=%h",
                         forced[t], pulses, got, expect_seed[t]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e < 5; e++) cycle(1'b0, 1'b0);
        tests_run++;
        if (dut.state_q !== start_key_pkg::StFall || dut.cnt_q !== 2'd3) begin
            fails++; $display("FAIL mid_pre got state=%0d cnt=%0d exp FALL,3", dut.state_q, dut.cnt_q);
        end
        cycle(1'b0, 1'b1);
        tests_run++;
        if (dut.state_q !== start_key_pkg::StUp || dut.cnt_q !== 2'd0 || o_start !== 1'b0
            || o_seed !== 32'd1 || o_pressed !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got state=%0d cnt=%0d start=%b seed=%h pressed=%b",
                     dut.state_q, dut.cnt_q, o_start, o_seed, o_pressed);
        end
        for (int e = 0; e < 9; e++) begin
            cycle(1'b0, 1'b0);
            tests_run++;
            if (o_start !== (e == 5)) begin
                fails++; $display("FAIL mid_repress e=%0d got=%b exp=%b", e, o_start, e == 5);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [31:0] seeds [2];
        logic k;
        do_reset();
        pulses = 0;
        seeds[0] = 32'hX; seeds[1] = 32'hX;
        for (int e = 0; e < 140; e++) begin
            k = ((e < 20) || (e >= 100 && e < 120)) ? 1'b0 : 1'b1;
            cycle(k, 1'b0);
            tests_run++;
            if (o_start !== m_start || (m_start && o_seed !== m_seed)) begin
                fails++;
                $display("FAIL b2b_model e=%0d got start=%b seed=%h exp start=%b seed=%h",
                         e, o_start, o_seed, m_start, m_seed);
            end
            if (o_start === 1'b1) begin
                if (pulses < 2) seeds[pulses] = o_seed;
                pulses++;
            end
        end
        tests_run++;
        if (pulses != 2 || seeds[0] !== 32'd5 || seeds[1] !== 32'd105) begin
            fails++;
            $display("FAIL b2b_pulses got n=%0d s0=%h s1=%h exp n=2 s0=5 s1=105",
                     pulses, seeds[0], seeds[1]);
        end
    endtask

    task automatic test_random();
        logic k;
        int run;
        do_reset();
        k = 1'b1;
        run = 0;
        for (int e = 0; e < 1500; e++) begin
            if (run == 0) begin
                k = ~k;
                run = $urandom_range(1, 8);
            end
            run--;
            cycle(k, ($urandom_range(0, 299) == 0));
            tests_run++;
            if (o_start !== m_start || o_pressed !== m_pressed || o_seed !== m_seed) begin
                fails++;
                $display("FAIL random e=%0d got start=%b pressed=%b seed=%h exp %b %b %h",
                         e, o_start, o_pressed, o_seed, m_start, m_pressed, m_seed);
            end
        end
    endtask

    initial begin
        model_edge(1'b1, 1'b1);
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_seed_legal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
